// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multicycle MIPS core.
// Steps the shared datapath through each instruction: fetch, decode and
// register read, ALU work, memory access, write-back and PC update.
//
// Ports
//   clk, reset  : core clock; synchronous active-high reset
//   Opcode      : Instr[31:26] from the instruction register
//   Funct       : Instr[5:0], selects the ALU op for R-type instructions
//   Zero        : ALU zero flag, gates the PC write in BRANCH
//   PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
//   ALUSrcA, ALUSrcB, ZeroExt, ALUControl, PCSrc : datapath controls
//   Illegal_op  : one-cycle pulse in DECODE for an unsupported opcode
//   State       : current state register, for debug
module multicycle_control_fsm #(
  parameter int OPCODE_WIDTH  = 6,
  parameter int STATE_WIDTH   = 4,
  parameter int ALUCTRL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OPCODE_WIDTH-1:0]  Opcode,
  input  logic [OPCODE_WIDTH-1:0]  Funct,
  input  logic                     Zero,
  output logic                     PCEn,
  output logic                     IorD,
  output logic                     MemWrite,
  output logic                     IRWrite,
  output logic                     RegWrite,
  output logic                     RegDst,
  output logic                     MemtoReg,
  output logic                     ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic                     ZeroExt,
  output logic [ALUCTRL_WIDTH-1:0] ALUControl,
  output logic [1:0]               PCSrc,
  output logic                     Illegal_op,
  output logic [STATE_WIDTH-1:0]   State
);

  // Sequential encoding: FETCH=0 ... JUMP=11; 12-15 are unreachable.
  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = OPCODE_WIDTH'(6'b000101);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = OPCODE_WIDTH'(6'b001101);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);

  localparam logic [OPCODE_WIDTH-1:0] FN_ADD = OPCODE_WIDTH'(6'b100000);
  localparam logic [OPCODE_WIDTH-1:0] FN_SUB = OPCODE_WIDTH'(6'b100010);
  localparam logic [OPCODE_WIDTH-1:0] FN_AND = OPCODE_WIDTH'(6'b100100);
  localparam logic [OPCODE_WIDTH-1:0] FN_OR  = OPCODE_WIDTH'(6'b100101);
  localparam logic [OPCODE_WIDTH-1:0] FN_SLT = OPCODE_WIDTH'(6'b101010);

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD = ALUCTRL_WIDTH'(3'b010);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB = ALUCTRL_WIDTH'(3'b110);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND = ALUCTRL_WIDTH'(3'b000);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR  = ALUCTRL_WIDTH'(3'b001);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT = ALUCTRL_WIDTH'(3'b111);

  state_t state, next_state;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  assign State = state;

  always_comb begin
    next_state = FETCH;
    PCEn       = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ZeroExt    = 1'b0;
    ALUControl = ALU_ADD;
    PCSrc      = 2'b00;
    Illegal_op = 1'b0;

    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcB    = 2'b01;
        PCEn       = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:   next_state = MEMADR;
          OP_RTYPE:       next_state = EXEC;
          OP_BEQ, OP_BNE: next_state = BRANCH;
          OP_ADDI, OP_ORI: next_state = IMMEX;
          OP_J:           next_state = JUMP;
          default: begin
            next_state = FETCH;
            Illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD       = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        case (Funct)
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          FN_OR:   ALUControl = ALU_OR;
          FN_SLT:  ALUControl = ALU_SLT;
          FN_ADD:  ALUControl = ALU_ADD;
          default: ALUControl = ALU_ADD;
        endcase
        next_state = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        // bne takes the branch when the compare is non-zero.
        PCEn       = (Opcode == OP_BNE) ? ~Zero : Zero;
      end
      IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (Opcode == OP_ORI) begin
          ALUControl = ALU_OR;
          ZeroExt    = 1'b1;
        end
        next_state = IMMWB;
      end
      IMMWB: RegWrite = 1'b1;
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ALUControl = '0;  // unreachable encodings: everything off
    endcase

    // Reset dominates: no strobe may fire while the core is being reset.
    if (reset) begin
      PCEn       = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ZeroExt    = 1'b0;
      ALUControl = '0;
      PCSrc      = 2'b00;
      Illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm. The stimulus process pushes
// the hand-derived expected output word for every cycle it drives; the
// monitor pops one entry per falling edge and compares the whole word.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       Zero;
  logic       PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ZeroExt;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       Illegal_op;
  logic [3:0] State;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .Illegal_op(Illegal_op),
    .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluctl;
    logic [1:0] pcsrc;
    logic       illegal;
    logic [3:0] state;
  } ov_t;

  typedef struct {
    ov_t   v;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Hand-written expected outputs for each state with its default
  // (opcode-independent) settings; tests override the dependent fields.
  function automatic ov_t st(input int s);
    ov_t e = '0;
    e.aluctl = 3'b010;
    e.state  = 4'(s);
    case (s)
      0:  begin e.irwrite = 1; e.alusrcb = 2'b01; e.pcen = 1; end
      1:  e.alusrcb = 2'b11;
      2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      3:  e.iord = 1;
      4:  begin e.regwrite = 1; e.memtoreg = 1; end
      5:  begin e.iord = 1; e.memwrite = 1; end
      6:  e.alusrca = 1;
      7:  begin e.regwrite = 1; e.regdst = 1; end
      8:  begin e.alusrca = 1; e.aluctl = 3'b110; e.pcsrc = 2'b01; end
      9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      10: e.regwrite = 1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ov_t rst_vec(input int s);
    ov_t e = '0;
    e.state = 4'(s);
    return e;
  endfunction

  // Monitor: the DUT presents a control word every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        exp_t e;
        ov_t  act;
        e   = q.pop_front();
        act = {PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
               ALUSrcB, ZeroExt, ALUControl, PCSrc, Illegal_op, State};
        n_chk++;
        if (act === e.v) n_pass++;
        else $display("FAIL %s: got %h want %h (state got %0d want %0d)",
                      e.name, act, e.v, act.state, e.v.state);
      end
    end
  end

  task automatic cyc(input ov_t e, input string name);
    exp_t x;
    x.v = e; x.name = name;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic instr_start(input logic [5:0] op, input logic [5:0] fn, input string name);
    Opcode = op; Funct = fn; Zero = 1'b0;
    cyc(st(0), {name, " fetch"});
    cyc(st(1), {name, " decode"});
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [2:0] alu, input string name);
    ov_t e;
    instr_start(6'b000000, fn, name);
    e = st(6); e.aluctl = alu;
    cyc(e, {name, " exec"});
    cyc(st(7), {name, " aluwb"});
  endtask

  task automatic branch(input logic [5:0] op, input logic z, input logic take, input string name);
    ov_t e;
    instr_start(op, 6'b000000, name);
    Zero = z;
    e = st(8); e.pcen = take;
    cyc(e, {name, " branch"});
    Zero = 1'b0;
  endtask

  initial begin
    ov_t e;
    reset = 1'b1; Opcode = 6'b000000; Funct = 6'b100000; Zero = 1'b0;
    @(posedge clk); #1;
    // Reset held two cycles: all controls low, State already FETCH.
    cyc(rst_vec(0), "reset c1");
    cyc(rst_vec(0), "reset c2");
    reset = 1'b0;

    rtype(6'b100000, 3'b010, "r-add");

    instr_start(6'b100011, 6'b000000, "lw");
    cyc(st(2), "lw memadr");
    cyc(st(3), "lw memrd");
    cyc(st(4), "lw memwb");

    instr_start(6'b101011, 6'b000000, "sw");
    cyc(st(2), "sw memadr");
    cyc(st(5), "sw memwr");

    branch(6'b000100, 1'b1, 1'b1, "beq z1");
    branch(6'b000100, 1'b0, 1'b0, "beq z0");
    branch(6'b000101, 1'b0, 1'b1, "bne z0");
    branch(6'b000101, 1'b1, 1'b0, "bne z1");

    rtype(6'b100010, 3'b110, "r-sub");
    rtype(6'b101010, 3'b111, "r-slt");
    rtype(6'b100100, 3'b000, "r-and");
    rtype(6'b100101, 3'b001, "r-or");
    rtype(6'b111111, 3'b010, "r-badfn");

    instr_start(6'b001101, 6'b000000, "ori");
    e = st(9); e.aluctl = 3'b001; e.zeroext = 1'b1;
    cyc(e, "ori immex");
    cyc(st(10), "ori immwb");

    instr_start(6'b001000, 6'b000000, "addi");
    cyc(st(9), "addi immex");
    cyc(st(10), "addi immwb");

    instr_start(6'b000010, 6'b000000, "j");
    cyc(st(11), "j jump");

    // Illegal opcode: pulse in DECODE, then straight back to FETCH.
    Opcode = 6'b111111; Funct = 6'b000000; Zero = 1'b0;
    cyc(st(0), "illegal fetch");
    e = st(1); e.illegal = 1'b1;
    cyc(e, "illegal decode");

    // Reset during MEMWR aborts the store with no write strobe.
    instr_start(6'b101011, 6'b000000, "sw-abort");
    cyc(st(2), "sw-abort memadr");
    reset = 1'b1;
    cyc(rst_vec(5), "sw-abort reset in memwr");
    reset = 1'b0;
    rtype(6'b100000, 3'b010, "post-reset r-add");
    cyc(st(0), "final fetch");

    // Let the monitor drain; an undrained queue counts as a failure.
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control unit for the multicycle MIPS core. It sequences the shared datapath on a per-instruction basis: instruction fetch, register-file read and write-back, ALU, memory port and PC update. Opcode and Funct come from the instruction register. Its outputs drive the datapath muxes and write enables, including the register-file write strobe and its write-register/write-data select.

Parameters:
OPCODE_WIDTH, 6, width of the Opcode and Funct fields
STATE_WIDTH, 4, width of the state register and the State debug port
ALUCTRL_WIDTH, 3, width of ALUControl

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high
Opcode  input  6  Instr[31:26] from the instruction register
Funct  input  6  Instr[5:0] from the instruction register
Zero  input  1  ALU zero flag, combinational from the current ALU result
PCEn  output  1  PC register enable
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction register load
RegWrite  output  1  register-file write strobe
RegDst  output  1  write-register select: 0 = rt, 1 = rd
MemtoReg  output  1  write-data select: 0 = ALUOut, 1 = memory data
ALUSrcA  output  1  0 = PC, 1 = register A
ALUSrcB  output  2  00 = register B, 01 = const 4, 10 = extended imm, 11 = extended imm<<2
ZeroExt  output  1  1 = zero-extend imm (ori), 0 = sign-extend
ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
Illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode
State  output  4  current state, for debug

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: on a rising edge with reset=1, state <= FETCH (0).
  - While reset=1, force all outputs to 0 combinationally: PCEn, IRWrite, MemWrite and RegWrite are low, and State still shows the register value.
- Moore outputs are decoded from state. Exceptions:
  - PCEn in BRANCH depends on Zero.
  - ALUControl in EXEC depends on Funct.
  - ALUControl and ZeroExt in IMMEX depend on Opcode.
- Default for every output not listed in a state: 0. Default ALUControl is 010.
- States, encoding, outputs and next state:
  - FETCH 0: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, PCEn=1. Next: DECODE.
  - DECODE 1: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut). Next by Opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) or 000101 (bne) -> BRANCH
    - 001000 (addi) or 001101 (ori) -> IMMEX
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH, with Illegal_op=1 this cycle
  - MEMADR 2: ALUSrcA=1, ALUSrcB=10, add. Next: MEMRD if lw, else MEMWR.
  - MEMRD 3: IorD=1. Next: MEMWB.
  - MEMWB 4: RegWrite=1, RegDst=0, MemtoReg=1. Next: FETCH.
  - MEMWR 5: IorD=1, MemWrite=1. Next: FETCH.
  - EXEC 6: ALUSrcA=1, ALUSrcB=00. ALUControl from Funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
    - other Funct -> 010
    - Next: ALUWB.
  - ALUWB 7: RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
  - BRANCH 8: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01.
    - PCEn = Zero for beq; PCEn = ~Zero for bne.
    - Next: FETCH.
  - IMMEX 9: ALUSrcA=1, ALUSrcB=10.
    - addi: ALUControl=010, ZeroExt=0.
    - ori: ALUControl=001, ZeroExt=1.
    - Next: IMMWB.
  - IMMWB 10: RegWrite=1, RegDst=0, MemtoReg=0. Next: FETCH.
  - JUMP 11: PCSrc=10, PCEn=1. Next: FETCH.
  - Encodings 12-15 are unreachable. If entered, all outputs are 0 and next state is FETCH.
- Latency in cycles, FETCH to next FETCH: lw 5; sw, R-type, addi, ori 4; beq, bne, j 3; illegal opcode 2.
- Opcode and Funct are sampled only in the states listed above. The IR changes only in FETCH, so Opcode and Funct are stable through the rest of each instruction.
- Reset asserted mid-instruction (e.g. in MEMWR) aborts the instruction. No write strobe fires in the reset cycle, and FETCH follows.
- At most one of RegWrite, MemWrite and IRWrite is high in any cycle.

Test Plan:
- Hold reset 2 cycles, then release with Opcode=000000 -> write strobes are 0 during reset; State=0 with PCEn=1 and IRWrite=1 in the first free cycle; State sequence 0,1,6,7,0.
- Opcode=100011 (lw) -> State sequence 0,1,2,3,4,0. RegWrite=1, MemtoReg=1, RegDst=0 only in state 4. IorD=1 only in state 3.
- Opcode=000100 (beq):
  - Zero=1 in state 8 -> PCEn=1, PCSrc=01.
  - Repeat with Zero=0 -> PCEn=0.
  - Opcode=000101 (bne) with Zero=0 -> PCEn=1.
- R-type with Funct 100010, 101010 and 111111 -> ALUControl in state 6 is 110, 111 and 010 respectively.
- Opcode=001101 (ori) -> in state 9, ZeroExt=1 and ALUControl=001. State 10 asserts RegWrite with RegDst=0.
- Opcode=111111 -> Illegal_op=1 for one cycle in state 1, next state 0. Separately, assert reset during state 5 -> MemWrite=0 that cycle and State=0 afterwards.
